// File: rtl/cache_way_sel_pipe_pkg.sv
// cache_way_sel_pipe_pkg: shared defaults, index types and tree pseudo-LRU helpers
package cache_way_sel_pipe_pkg;
  localparam int CACHE_WAYS = 2;
  localparam int CACHE_LINE_W = 128;
  localparam int CACHE_WORD_W = 32;
  localparam int CACHE_SETS = 256;
  typedef logic [2:0] way_idx_t;
  typedef logic [$clog2(CACHE_SETS)-1:0] set_idx_t;
  typedef logic [6:0] plru_t;
  // Heap-ordered tree: node n lives in bit n-1, children of n are 2n and 2n+1
  function automatic way_idx_t plru_victim(input plru_t s, input int ways);
    int n;
    n = 1;
    for (int m = ways >> 1; m > 0; m = m >> 1) n = 2 * n + int'(s[n-1]);
    return way_idx_t'(n - ways);
  endfunction
  function automatic plru_t plru_update(input plru_t s, input way_idx_t w, input int ways);
    plru_t r;
    logic d;
    int n;
    r = s;
    n = 1;
    for (int m = ways >> 1; m > 0; m = m >> 1) begin
      d = (int'(w) & m) != 0;
      r[n-1] = !d;
      n = 2 * n + int'(d);
    end
    return r;
  endfunction
endpackage

// File: rtl/cache_way_sel_pipe_if.sv
// cache_way_sel_pipe_if: lookup request and registered result handshake bundle
interface cache_way_sel_pipe_if
  import cache_way_sel_pipe_pkg::*;
#(
  parameter int WAYS = CACHE_WAYS,
  parameter int LINE_W = CACHE_LINE_W,
  parameter int WORD_W = CACHE_WORD_W,
  parameter int SETS = CACHE_SETS
);
  logic in_valid;
  logic in_ready;
  logic [WAYS-1:0] hit;
  logic [WAYS*LINE_W-1:0] r_data;
  logic [$clog2(SETS)-1:0] index;
  logic [$clog2(LINE_W/WORD_W)-1:0] offset;
  logic out_valid;
  logic out_ready;
  logic out_hit;
  logic [$clog2(WAYS)-1:0] out_way;
  logic [LINE_W-1:0] out_line;
  logic [WORD_W-1:0] out_word;
  logic out_multihit;
  modport master (
    output in_valid, hit, r_data, index, offset, out_ready,
    input in_ready, out_valid, out_hit, out_way, out_line, out_word, out_multihit
  );
  modport slave (
    input in_valid, hit, r_data, index, offset, out_ready,
    output in_ready, out_valid, out_hit, out_way, out_line, out_word, out_multihit
  );
endinterface

// File: rtl/cache_way_sel_pipe_plru_tree.sv
// cache_way_sel_pipe_plru_tree: per-set tree PLRU state, victim read, hit/fill update with fill priority
module cache_way_sel_pipe_plru_tree
  import cache_way_sel_pipe_pkg::*;
#(
  parameter int WAYS = CACHE_WAYS,
  parameter int SETS = CACHE_SETS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(SETS)-1:0] rd_index,
  output logic [$clog2(WAYS)-1:0] victim,
  input  logic                    hit_en,
  input  logic [$clog2(SETS)-1:0] hit_index,
  input  logic [$clog2(WAYS)-1:0] hit_way,
  input  logic                    fill_en,
  input  logic [$clog2(SETS)-1:0] fill_index,
  input  logic [$clog2(WAYS)-1:0] fill_way
);
  localparam int NB = WAYS - 1;
  localparam int WW = $clog2(WAYS);
  logic [NB-1:0] state [SETS];
  assign victim = WW'(plru_victim(plru_t'(state[rd_index]), WAYS));
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int s = 0; s < SETS; s++) state[s] <= '0;
    else begin
      if (hit_en && !(fill_en && fill_index == hit_index))
        state[hit_index] <= NB'(plru_update(plru_t'(state[hit_index]), way_idx_t'(hit_way), WAYS));
      if (fill_en)
        state[fill_index] <= NB'(plru_update(plru_t'(state[fill_index]), way_idx_t'(fill_way), WAYS));
    end
endmodule

// File: rtl/cache_way_sel_pipe.sv
// cache_way_sel_pipe: hit-way select, word extract and registered result; CACHE_MULTIHIT_CHK_EN adds multihit flag
module cache_way_sel_pipe
  import cache_way_sel_pipe_pkg::*;
#(
  parameter int WAYS = CACHE_WAYS,
  parameter int LINE_W = CACHE_LINE_W,
  parameter int WORD_W = CACHE_WORD_W,
  parameter int SETS = CACHE_SETS
) (
  input logic                    clk,
  input logic                    rst,
  cache_way_sel_pipe_if.slave    bus,
  input logic                    fill_valid,
  input logic [$clog2(SETS)-1:0] fill_index,
  input logic [$clog2(WAYS)-1:0] fill_way
);
  localparam int WW = $clog2(WAYS);
  logic accept;
  logic any_hit;
  logic [WW-1:0] sel_way;
  logic [WW-1:0] victim;
  logic [LINE_W-1:0] sel_line;
  logic [WORD_W-1:0] sel_word;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign any_hit = |bus.hit;
  // Later ways overwrite earlier ones, so the highest set hit bit wins
  always_comb begin
    sel_way = '0;
    sel_line = '0;
    for (int w = 0; w < WAYS; w++)
      if (bus.hit[w]) begin
        sel_way = WW'(w);
        sel_line = bus.r_data[w*LINE_W +: LINE_W];
      end
  end
  assign sel_word = sel_line[bus.offset*WORD_W +: WORD_W];
  cache_way_sel_pipe_plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (bus.index),
    .victim     (victim),
    .hit_en     (accept && any_hit),
    .hit_index  (bus.index),
    .hit_way    (sel_way),
    .fill_en    (fill_valid),
    .fill_index (fill_index),
    .fill_way   (fill_way)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_hit <= 1'b0;
      bus.out_way <= '0;
      bus.out_line <= '0;
      bus.out_word <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_hit <= any_hit;
      bus.out_way <= any_hit ? sel_way : victim;
      bus.out_line <= sel_line;
      bus.out_word <= sel_word;
    end else if (bus.out_ready)
      bus.out_valid <= 1'b0;
`ifdef CACHE_MULTIHIT_CHK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.out_multihit <= 1'b0;
    else if (accept) bus.out_multihit <= $countones(bus.hit) > 1;
`else
  assign bus.out_multihit = 1'b0;
`endif
endmodule

// File: tb/tb_cache_way_sel_pipe.sv
// tb_cache_way_sel_pipe: directed 2-way/4-way scenarios plus randomized 4-way run against a tree-PLRU model
module tb_cache_way_sel_pipe;
`ifdef CACHE_MULTIHIT_CHK_EN
  localparam bit MH_EN = 1'b1;
`else
  localparam bit MH_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic f2_v, f4_v;
  logic [7:0] f2_i;
  logic [2:0] f4_i;
  logic f2_w;
  logic [1:0] f4_w;
  logic [127:0] l0, l1, l2, l3;
  bit m_root [8];
  bit m_left [8];
  bit m_right [8];
  always #5 clk = ~clk;
  cache_way_sel_pipe_if #(.WAYS(2)) i2 ();
  cache_way_sel_pipe_if #(.WAYS(4), .SETS(8)) i4 ();
  cache_way_sel_pipe #(.WAYS(2)) d2 (
    .clk(clk), .rst(rst), .bus(i2), .fill_valid(f2_v), .fill_index(f2_i), .fill_way(f2_w)
  );
  cache_way_sel_pipe #(.WAYS(4), .SETS(8)) d4 (
    .clk(clk), .rst(rst), .bus(i4), .fill_valid(f4_v), .fill_index(f4_i), .fill_way(f4_w)
  );

  // 4-way tree: root chooses half (1 = upper), leaf nodes choose within the half
  function automatic void touch(input int s, input int w);
    m_root[s] = w < 2;
    if (w < 2) m_left[s] = (w == 0);
    else m_right[s] = (w == 2);
  endfunction

  function automatic int model_victim(input int s);
    return m_root[s] ? (m_right[s] ? 3 : 2) : (m_left[s] ? 1 : 0);
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle();
    i2.in_valid = 0; i2.out_ready = 1; i2.hit = '0; i2.r_data = '0; i2.index = '0; i2.offset = '0;
    i4.in_valid = 0; i4.out_ready = 1; i4.hit = '0; i4.r_data = '0; i4.index = '0; i4.offset = '0;
    f2_v = 0; f2_i = '0; f2_w = '0; f4_v = 0; f4_i = '0; f4_w = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    for (int s = 0; s < 8; s++) begin m_root[s] = 0; m_left[s] = 0; m_right[s] = 0; end
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    n_cmp++; if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid2 got %b want 0", i2.out_valid); end
    n_cmp++; if (i2.out_hit !== 1'b0) begin n_bad++; $display("FAIL rst_hit2 got %b want 0", i2.out_hit); end
    n_cmp++; if (i2.out_way !== 1'b0) begin n_bad++; $display("FAIL rst_way2 got %h want 0", i2.out_way); end
    n_cmp++; if (i2.out_line !== '0) begin n_bad++; $display("FAIL rst_line2 got %h want 0", i2.out_line); end
    n_cmp++; if (i2.out_word !== '0) begin n_bad++; $display("FAIL rst_word2 got %h want 0", i2.out_word); end
    n_cmp++; if (i2.out_multihit !== 1'b0) begin n_bad++; $display("FAIL rst_mh2 got %b want 0", i2.out_multihit); end
    n_cmp++; if (i2.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready2 got %b want 1", i2.in_ready); end
    n_cmp++; if (i4.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid4 got %b want 0", i4.out_valid); end
    rst = 0;
  endtask

  task automatic test_hit_word();
    l0 = rnd_line(); l1 = rnd_line();
    @(negedge clk);
    i2.in_valid = 1; i2.hit = 2'b01; i2.r_data = {l1, l0}; i2.index = 8'd7; i2.offset = 2'd2;
    @(negedge clk);
    i2.in_valid = 0;
    n_cmp++; if (i2.out_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid got %b want 1", i2.out_valid); end
    n_cmp++; if (i2.out_hit !== 1'b1) begin n_bad++; $display("FAIL t1_hit got %b want 1", i2.out_hit); end
    n_cmp++; if (i2.out_way !== 1'b0) begin n_bad++; $display("FAIL t1_way got %h want 0", i2.out_way); end
    n_cmp++; if (i2.out_word !== l0[95:64]) begin n_bad++; $display("FAIL t1_word got %h want %h", i2.out_word, l0[95:64]); end
    n_cmp++; if (i2.out_line !== l0) begin n_bad++; $display("FAIL t1_line got %h want %h", i2.out_line, l0); end
    n_cmp++; if (i2.out_multihit !== 1'b0) begin n_bad++; $display("FAIL t1_mh got %b want 0", i2.out_multihit); end
    @(negedge clk);
    n_cmp++; if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_drain got %b want 0", i2.out_valid); end
  endtask

  task automatic test_multihit();
    l0 = rnd_line(); l1 = rnd_line();
    i2.in_valid = 1; i2.hit = 2'b11; i2.r_data = {l1, l0}; i2.index = 8'd9; i2.offset = 2'd1;
    @(negedge clk);
    i2.in_valid = 0;
    n_cmp++; if (i2.out_way !== 1'b1) begin n_bad++; $display("FAIL t2_way got %h want 1", i2.out_way); end
    n_cmp++; if (i2.out_hit !== 1'b1) begin n_bad++; $display("FAIL t2_hit got %b want 1", i2.out_hit); end
    n_cmp++; if (i2.out_line !== l1) begin n_bad++; $display("FAIL t2_line got %h want %h", i2.out_line, l1); end
    n_cmp++; if (i2.out_word !== l1[63:32]) begin n_bad++; $display("FAIL t2_word got %h want %h", i2.out_word, l1[63:32]); end
    n_cmp++; if (i2.out_multihit !== MH_EN) begin n_bad++; $display("FAIL t2_mh got %b want %b", i2.out_multihit, MH_EN); end
  endtask

  task automatic test_miss_victim();
    do_reset();
    i2.in_valid = 1; i2.hit = 2'b00; i2.r_data = {rnd_line(), rnd_line()}; i2.index = 8'd5; i2.offset = 2'd3;
    @(negedge clk);
    n_cmp++; if (i2.out_hit !== 1'b0) begin n_bad++; $display("FAIL t3_hit got %b want 0", i2.out_hit); end
    n_cmp++; if (i2.out_line !== '0) begin n_bad++; $display("FAIL t3_line got %h want 0", i2.out_line); end
    n_cmp++; if (i2.out_word !== '0) begin n_bad++; $display("FAIL t3_word got %h want 0", i2.out_word); end
    n_cmp++; if (i2.out_way !== 1'b0) begin n_bad++; $display("FAIL t3_vic0 got %h want 0", i2.out_way); end
    n_cmp++; if (i2.out_valid !== 1'b1) begin n_bad++; $display("FAIL t3_valid got %b want 1", i2.out_valid); end
    i2.hit = 2'b01;
    @(negedge clk);
    n_cmp++; if (i2.out_way !== 1'b0 || i2.out_hit !== 1'b1) begin n_bad++; $display("FAIL t3_hitway got %h/%b want 0/1", i2.out_way, i2.out_hit); end
    i2.hit = 2'b00;
    @(negedge clk);
    i2.in_valid = 0;
    n_cmp++; if (i2.out_way !== 1'b1) begin n_bad++; $display("FAIL t3_vic1 got %h want 1", i2.out_way); end
  endtask

  task automatic test_backpressure();
    l0 = rnd_line(); l1 = rnd_line(); l2 = rnd_line(); l3 = rnd_line();
    @(negedge clk);
    i2.out_ready = 0;
    i2.in_valid = 1; i2.hit = 2'b10; i2.r_data = {l1, l0}; i2.index = 8'd20; i2.offset = 2'd0;
    @(negedge clk);
    i2.hit = 2'b01; i2.r_data = {l3, l2}; i2.index = 8'd21; i2.offset = 2'd3;
    n_cmp++; if (i2.out_valid !== 1'b1) begin n_bad++; $display("FAIL t4_valid got %b want 1", i2.out_valid); end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (i2.in_ready !== 1'b0) begin n_bad++; $display("FAIL t4_ready%0d got %b want 0", k, i2.in_ready); end
      @(negedge clk);
      n_cmp++; if (i2.out_valid !== 1'b1 || i2.out_way !== 1'b1 || i2.out_word !== l1[31:0] || i2.out_line !== l1) begin
        n_bad++; $display("FAIL t4_hold%0d got v=%b way=%h word=%h want v=1 way=1 word=%h", k, i2.out_valid, i2.out_way, i2.out_word, l1[31:0]);
      end
    end
    i2.out_ready = 1;
    #1;
    n_cmp++; if (i2.in_ready !== 1'b1) begin n_bad++; $display("FAIL t4_release got %b want 1", i2.in_ready); end
    @(negedge clk);
    i2.in_valid = 0;
    n_cmp++; if (i2.out_way !== 1'b0 || i2.out_word !== l2[127:96] || i2.out_line !== l2) begin
      n_bad++; $display("FAIL t4_next got way=%h word=%h want way=0 word=%h", i2.out_way, i2.out_word, l2[127:96]);
    end
  endtask

  task automatic test_fill_priority();
    do_reset();
    i4.in_valid = 1; i4.hit = 4'b0100; i4.index = 3'd3; i4.offset = 2'd1;
    for (int k = 0; k < 16; k++) i4.r_data[k*32 +: 32] = $urandom();
    f4_v = 1; f4_i = 3'd3; f4_w = 2'd1;
    @(negedge clk);
    f4_v = 0;
    n_cmp++; if (i4.out_way !== 2'd2 || i4.out_hit !== 1'b1) begin n_bad++; $display("FAIL t5_hit got %h/%b want 2/1", i4.out_way, i4.out_hit); end
    i4.hit = 4'b0000;
    @(negedge clk);
    n_cmp++; if (i4.out_way !== 2'd2 || i4.out_hit !== 1'b0) begin n_bad++; $display("FAIL t5_vic got %h/%b want 2/0", i4.out_way, i4.out_hit); end
    i4.hit = 4'b1000; i4.index = 3'd4;
    f4_v = 1; f4_i = 3'd6; f4_w = 2'd0;
    @(negedge clk);
    f4_v = 0;
    n_cmp++; if (i4.out_way !== 2'd3) begin n_bad++; $display("FAIL t5_hit3 got %h want 3", i4.out_way); end
    i4.hit = 4'b0000;
    @(negedge clk);
    n_cmp++; if (i4.out_way !== 2'd0) begin n_bad++; $display("FAIL t5_vic4 got %h want 0", i4.out_way); end
    i4.index = 3'd6;
    @(negedge clk);
    i4.in_valid = 0;
    n_cmp++; if (i4.out_way !== 2'd2) begin n_bad++; $display("FAIL t5_vic6 got %h want 2", i4.out_way); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    i2.out_ready = 0;
    i2.in_valid = 1; i2.hit = 2'b01; i2.r_data = {rnd_line(), rnd_line()}; i2.index = 8'd5;
    @(negedge clk);
    i2.in_valid = 0;
    n_cmp++; if (i2.out_valid !== 1'b1) begin n_bad++; $display("FAIL t6_pre got %b want 1", i2.out_valid); end
    #2 rst = 1;
    #1;
    n_cmp++; if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL t6_async got %b want 0", i2.out_valid); end
    n_cmp++; if (i2.out_line !== '0) begin n_bad++; $display("FAIL t6_line got %h want 0", i2.out_line); end
    @(negedge clk);
    rst = 0;
    for (int s = 0; s < 8; s++) begin m_root[s] = 0; m_left[s] = 0; m_right[s] = 0; end
    i2.out_ready = 1; i2.in_valid = 1; i2.hit = 2'b00; i2.index = 8'd5;
    i4.in_valid = 1; i4.hit = 4'b0000; i4.index = 3'd3;
    @(negedge clk);
    i2.in_valid = 0; i4.in_valid = 0;
    n_cmp++; if (i2.out_valid !== 1'b1 || i2.out_way !== 1'b0) begin n_bad++; $display("FAIL t6_vic2 got %b/%h want 1/0", i2.out_valid, i2.out_way); end
    n_cmp++; if (i4.out_valid !== 1'b1 || i4.out_way !== 2'd0) begin n_bad++; $display("FAIL t6_vic4 got %b/%h want 1/0", i4.out_valid, i4.out_way); end
  endtask

  task automatic test_random();
    logic ev, eh, emh, rdy, acc;
    logic [1:0] ew;
    logic [127:0] eline;
    logic [31:0] eword;
    int hw, sel, idx;
    do_reset();
    idle();
    ev = 0; eh = 0; emh = 0; ew = '0; eline = '0; eword = '0;
    for (int c = 0; c < 400; c++) begin
      i4.in_valid = $urandom_range(0, 3) != 0;
      i4.out_ready = $urandom_range(0, 3) != 0;
      sel = $urandom_range(0, 5);
      i4.hit = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'($urandom()) : 4'(1 << $urandom_range(0, 3));
      i4.index = 3'($urandom()); i4.offset = 2'($urandom());
      for (int k = 0; k < 16; k++) i4.r_data[k*32 +: 32] = $urandom();
      f4_v = $urandom_range(0, 2) == 0; f4_i = 3'($urandom()); f4_w = 2'($urandom());
      rdy = !ev || i4.out_ready;
      #1;
      n_cmp++; if (i4.in_ready !== rdy) begin n_bad++; $display("FAIL rnd_ready c%0d got %b want %b", c, i4.in_ready, rdy); end
      acc = i4.in_valid && rdy;
      idx = int'(i4.index);
      hw = -1;
      for (int w = 0; w < 4; w++) if (i4.hit[w]) hw = w;
      if (acc) begin
        eh = hw >= 0;
        ew = 2'(eh ? hw : model_victim(idx));
        eline = '0;
        if (eh) eline = i4.r_data[hw*128 +: 128];
        eword = eline[i4.offset*32 +: 32];
        emh = MH_EN && ($countones(i4.hit) > 1);
        ev = 1;
      end else if (i4.out_ready) ev = 0;
      if (acc && hw >= 0 && !(f4_v && int'(f4_i) == idx)) touch(idx, hw);
      if (f4_v) touch(int'(f4_i), int'(f4_w));
      @(negedge clk);
      n_cmp++; if (i4.out_valid !== ev) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", c, i4.out_valid, ev); end
      n_cmp++; if (i4.out_hit !== eh) begin n_bad++; $display("FAIL rnd_hit c%0d got %b want %b", c, i4.out_hit, eh); end
      n_cmp++; if (i4.out_way !== ew) begin n_bad++; $display("FAIL rnd_way c%0d got %h want %h", c, i4.out_way, ew); end
      n_cmp++; if (i4.out_line !== eline) begin n_bad++; $display("FAIL rnd_line c%0d got %h want %h", c, i4.out_line, eline); end
      n_cmp++; if (i4.out_word !== eword) begin n_bad++; $display("FAIL rnd_word c%0d got %h want %h", c, i4.out_word, eword); end
      n_cmp++; if (i4.out_multihit !== emh) begin n_bad++; $display("FAIL rnd_mh c%0d got %b want %b", c, i4.out_multihit, emh); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_hit_word();
    test_multihit();
    test_miss_victim();
    test_backpressure();
    test_fill_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
